// File: rtl/lc3_ctrl_pkg.sv
// Shared opcode constants, memory FSM state encoding and instruction-class helpers
// for the LC3 pipeline controller.
package lc3_ctrl_pkg;

    localparam logic [3:0] OpBr  = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpLd  = 4'b0010;
    localparam logic [3:0] OpSt  = 4'b0011;
    localparam logic [3:0] OpAnd = 4'b0101;
    localparam logic [3:0] OpLdr = 4'b0110;
    localparam logic [3:0] OpStr = 4'b0111;
    localparam logic [3:0] OpNot = 4'b1001;
    localparam logic [3:0] OpLdi = 4'b1010;
    localparam logic [3:0] OpSti = 4'b1011;
    localparam logic [3:0] OpJmp = 4'b1100;
    localparam logic [3:0] OpLea = 4'b1110;

    typedef enum logic [1:0] {
        MemRead  = 2'd0,
        MemInd   = 2'd1,
        MemWrite = 2'd2,
        MemIdle  = 2'd3
    } mem_state_e;

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OpAdd) || (op == OpAnd) || (op == OpNot) || (op == OpLea);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == OpLd) || (op == OpLdr) || (op == OpLdi);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OpSt) || (op == OpStr) || (op == OpSti);
    endfunction

    function automatic logic is_ctrl(input logic [3:0] op);
        return (op == OpBr) || (op == OpJmp);
    endfunction

    function automatic logic src1_used(input logic [3:0] op);
        return (op == OpAdd) || (op == OpAnd) || (op == OpNot) ||
               (op == OpLdr) || (op == OpStr) || (op == OpJmp);
    endfunction

    // Only register-register ADD/AND read SR2; bit 5 selects the immediate form.
    function automatic logic src2_used(input logic [3:0] op, input logic imm_sel);
        return ((op == OpAdd) || (op == OpAnd)) && !imm_sel;
    endfunction

endpackage

// File: rtl/lc3_mem_fsm.sv
// Data-memory access sequencer: tracks READ / IND / WRITE / IDLE and flags the
// cycle in which a load result is written back.
module lc3_mem_fsm
    import lc3_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] op_i,
    input  logic       complete_data_i,
    output logic [1:0] state_o,
    output logic       wb_pulse_o
);

    mem_state_e state_q, state_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= MemIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wb_pulse_o = 1'b0;
        unique case (state_q)
            MemIdle: begin
                if (start_i) begin
                    if ((op_i == OpLdi) || (op_i == OpSti)) begin
                        state_d = MemInd;
                    end else if (is_load(op_i)) begin
                        state_d = MemRead;
                    end else if (is_store(op_i)) begin
                        state_d = MemWrite;
                    end
                end
            end
            MemInd: begin
                if (complete_data_i) begin
                    state_d = (op_i == OpLdi) ? MemRead : MemWrite;
                end
            end
            MemRead: begin
                if (complete_data_i) begin
                    state_d    = MemIdle;
                    // Suppressed under reset so an aborted load never writes back.
                    wb_pulse_o = !rst_i;
                end
            end
            MemWrite: begin
                if (complete_data_i) begin
                    state_d = MemIdle;
                end
            end
            default: state_d = MemIdle;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/lc3_pipe_ctrl.sv
// LC3 pipeline controller: stage enables with reset fill ramp, branch stall counter,
// branch resolution and ALU/memory bypass selects.
module lc3_pipe_ctrl
    import lc3_ctrl_pkg::*;
#(
    parameter int unsigned BR_STALL = 3,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              complete_instr,
    input  logic              complete_data,
    input  logic [ADDR_W-1:0] IMem_dout,
    input  logic [ADDR_W-1:0] IR,
    input  logic [ADDR_W-1:0] IR_Exec,
    input  logic [2:0]        psr,
    output logic              enable_updatePC,
    output logic              enable_fetch,
    output logic              enable_decode,
    output logic              enable_execute,
    output logic              enable_writeback,
    output logic              bypass_alu_1,
    output logic              bypass_alu_2,
    output logic              bypass_mem_1,
    output logic              bypass_mem_2,
    output logic [1:0]        mem_state,
    output logic              br_taken
);

    localparam int unsigned CntW     = $clog2(BR_STALL + 1);
    localparam logic [2:0]  FillFull = 3'd4;

    logic [2:0]      fill_q, fill_d;
    logic [CntW-1:0] stall_q, stall_d;
    logic            br_taken_q, br_taken_d;
    logic [2:0]      mem_dr_q, mem_dr_d;
    logic            mem_valid_q, mem_valid_d;

    logic       mem_idle, wb_pulse, run, alu_ok, s1_used, s2_used;
    logic [1:0] mem_state_w;
    logic [3:0] op_fetch, op_dec, op_exec;
    logic [2:0] exec_dr;
    logic       unused_bits;

    assign op_fetch    = IMem_dout[15:12];
    assign op_dec      = IR[15:12];
    assign op_exec     = IR_Exec[15:12];
    assign exec_dr     = IR_Exec[11:9];
    assign unused_bits = ^{IMem_dout[11:0], IR[11:9], IR[4:3], IR_Exec[8:0]};

    lc3_mem_fsm u_mem_fsm (
        .clk_i           (clock),
        .rst_i           (reset),
        .start_i         (enable_execute),
        .op_i            (op_exec),
        .complete_data_i (complete_data),
        .state_o         (mem_state_w),
        .wb_pulse_o      (wb_pulse)
    );

    assign mem_state = mem_state_w;
    assign mem_idle  = (mem_state_w == MemIdle);
    assign run       = complete_instr && mem_idle;

    always_comb begin
        enable_updatePC  = run && (fill_q >= 3'd1) && (stall_q == '0);
        enable_fetch     = enable_updatePC;
        enable_decode    = run && (fill_q >= 3'd2);
        enable_execute   = run && (fill_q >= 3'd3);
        enable_writeback = mem_idle ? (fill_q >= FillFull) : wb_pulse;
    end

    always_comb begin
        s1_used      = src1_used(op_dec);
        s2_used      = src2_used(op_dec, IR[5]);
        alu_ok       = enable_execute && is_alu(op_exec);
        bypass_alu_1 = alu_ok && s1_used && (IR[8:6] == exec_dr);
        bypass_alu_2 = alu_ok && s2_used && (IR[2:0] == exec_dr);
        bypass_mem_1 = mem_valid_q && s1_used && (IR[8:6] == mem_dr_q) && !bypass_alu_1;
        bypass_mem_2 = mem_valid_q && s2_used && (IR[2:0] == mem_dr_q) && !bypass_alu_2;
    end

    always_comb begin
        fill_d = fill_q;
        if (complete_instr && (fill_q != FillFull)) begin
            fill_d = fill_q + 3'd1;
        end

        // Memory and instruction stalls both freeze the branch countdown.
        stall_d = stall_q;
        if (enable_fetch && is_ctrl(op_fetch)) begin
            stall_d = CntW'(BR_STALL);
        end else if ((stall_q != '0) && run) begin
            stall_d = stall_q - CntW'(1);
        end

        br_taken_d = enable_execute &&
                     ((op_exec == OpJmp) || ((op_exec == OpBr) && |(exec_dr & psr)));

        mem_dr_d    = mem_dr_q;
        mem_valid_d = mem_valid_q;
        if (wb_pulse) begin
            mem_dr_d    = exec_dr;
            mem_valid_d = 1'b1;
        end else if (mem_valid_q && enable_execute) begin
            mem_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fill_q      <= '0;
            stall_q     <= '0;
            br_taken_q  <= 1'b0;
            mem_dr_q    <= '0;
            mem_valid_q <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            stall_q     <= stall_d;
            br_taken_q  <= br_taken_d;
            mem_dr_q    <= mem_dr_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    assign br_taken = br_taken_q;

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Directed bench for lc3_pipe_ctrl: fill ramp, bypass selects, memory FSM,
// branch stall, br_taken, instruction stall and reset during a load.
module tb_lc3_pipe_ctrl;

    logic        clock, reset, complete_instr, complete_data;
    logic [15:0] IMem_dout, IR, IR_Exec;
    logic [2:0]  psr;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, br_taken;
    logic [1:0]  mem_state;

    logic [15:0] en_v, byp_v, ms_v, br_v;
    int          n_checks = 0;
    int          n_fail   = 0;

    lc3_pipe_ctrl #(
        .BR_STALL (3),
        .ADDR_W   (16)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .IMem_dout        (IMem_dout),
        .IR               (IR),
        .IR_Exec          (IR_Exec),
        .psr              (psr),
        .enable_updatePC  (enable_updatePC),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2),
        .bypass_mem_1     (bypass_mem_1),
        .bypass_mem_2     (bypass_mem_2),
        .mem_state        (mem_state),
        .br_taken         (br_taken)
    );

    // Enables packed as {updatePC, fetch, decode, execute, writeback}.
    assign en_v  = {11'b0, enable_updatePC, enable_fetch, enable_decode, enable_execute,
                    enable_writeback};
    assign byp_v = {12'b0, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2};
    assign ms_v  = {14'b0, mem_state};
    assign br_v  = {15'b0, br_taken};

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clock = 1'b0; reset = 1'b1; complete_instr = 1'b1; complete_data = 1'b0;
        IMem_dout = 16'h1000; IR = 16'h0000; IR_Exec = 16'h1000; psr = 3'b000;

        cyc(); cyc(); #1;
        check_eq("rst_en",  en_v,  16'b00000);
        check_eq("rst_ms",  ms_v,  16'd3);
        check_eq("rst_byp", byp_v, 16'b0000);
        check_eq("rst_br",  br_v,  16'd0);

        reset = 1'b0;
        cyc(); #1; check_eq("fill1", en_v, 16'b11000);
        cyc(); #1; check_eq("fill2", en_v, 16'b11100);
        cyc(); #1; check_eq("fill3", en_v, 16'b11110);
        cyc(); #1; check_eq("fill4", en_v, 16'b11111);
        check_eq("fill_ms", ms_v, 16'd3);

        IR_Exec = 16'h16C2; IR = 16'h18C1; #1 check_eq("alu_sr1", byp_v, 16'b1000);
        IR = 16'h1083; #1 check_eq("alu_sr2", byp_v, 16'b0100);
        IR = 16'h10E3; #1 check_eq("alu_imm", byp_v, 16'b1000);
        IR_Exec = 16'h2602; IR = 16'h18C1; #1 check_eq("alu_nonalu", byp_v, 16'b0000);
        IR_Exec = 16'h1000;

        // LDI R3 with two-cycle data latency in each phase
        IR_Exec = 16'hA605; IR = 16'h12C3; #1 check_eq("ldi_pre", ms_v, 16'd3);
        cyc(); #1 check_eq("ind_ms", ms_v, 16'd1);
        check_eq("ind_en", en_v, 16'b00000);
        cyc(); #1 check_eq("ind_ms2", ms_v, 16'd1);
        complete_data = 1'b1; #1 check_eq("ind_done_en", en_v, 16'b00000);
        cyc(); complete_data = 1'b0; #1 check_eq("rd_ms", ms_v, 16'd0);
        check_eq("rd_en", en_v, 16'b00000);
        cyc(); #1 check_eq("rd_ms2", ms_v, 16'd0);
        complete_data = 1'b1; #1 check_eq("rd_wb", en_v, 16'b00001);
        cyc(); complete_data = 1'b0; #1 check_eq("post_ms", ms_v, 16'd3);
        check_eq("mem_byp", byp_v, 16'b0011);
        check_eq("post_en", en_v, 16'b11111);
        IR_Exec = 16'h16C2; #1 check_eq("alu_wins", byp_v, 16'b1100);
        IR_Exec = 16'h1000;
        cyc(); #1 check_eq("memv_clr", byp_v, 16'b0000);

        // BRz fetched: three stall cycles; BRz executing with Z set redirects
        IMem_dout = 16'h0403; #1 check_eq("br_fetch", en_v, 16'b11111);
        cyc(); IMem_dout = 16'h1000; IR_Exec = 16'h0403; psr = 3'b010;
        #1 check_eq("brs1", en_v, 16'b00111);
        check_eq("br_pre", br_v, 16'd0);
        cyc(); IR_Exec = 16'h1000; #1 check_eq("brs2", en_v, 16'b00111);
        check_eq("br_pulse", br_v, 16'd1);
        cyc(); #1 check_eq("brs3", en_v, 16'b00111);
        check_eq("br_end", br_v, 16'd0);
        cyc(); #1 check_eq("brs_done", en_v, 16'b11111);

        IR_Exec = 16'h0403; psr = 3'b001; cyc(); IR_Exec = 16'h1000;
        #1 check_eq("br_nt", br_v, 16'd0);
        IR_Exec = 16'hC1C0; cyc(); IR_Exec = 16'h1000;
        #1 check_eq("jmp", br_v, 16'd1);
        cyc(); #1 check_eq("jmp_end", br_v, 16'd0);
        IR_Exec = 16'h0003; psr = 3'b111; cyc(); IR_Exec = 16'h1000;
        #1 check_eq("br_nzp0", br_v, 16'd0);

        // Instruction stall in steady state
        complete_instr = 1'b0; #1 check_eq("istall1", en_v, 16'b00001);
        cyc(); #1 check_eq("istall2", en_v, 16'b00001);
        cyc(); complete_instr = 1'b1; #1 check_eq("istall_end", en_v, 16'b11111);

        // Instruction stall while the branch counter is loaded: counter holds
        IMem_dout = 16'h0403; #1 check_eq("hb_fetch", en_v, 16'b11111);
        cyc(); IMem_dout = 16'h1000; complete_instr = 1'b0;
        #1 check_eq("hb_is1", en_v, 16'b00001);
        cyc(); #1 check_eq("hb_is2", en_v, 16'b00001);
        cyc(); complete_instr = 1'b1; #1 check_eq("hold1", en_v, 16'b00111);
        cyc(); #1 check_eq("hold2", en_v, 16'b00111);
        cyc(); #1 check_eq("hold3", en_v, 16'b00111);
        cyc(); #1 check_eq("hold_done", en_v, 16'b11111);

        complete_data = 1'b1; cyc(); complete_data = 1'b0;
        #1 check_eq("cd_idle", ms_v, 16'd3);

        // Reset while a load is in READ with data arriving
        IR_Exec = 16'h2605; cyc(); IR_Exec = 16'h1000;
        #1 check_eq("ld_rd", ms_v, 16'd0);
        reset = 1'b1; complete_data = 1'b1;
        #1 check_eq("rst_rd_en", en_v, 16'b00000);
        cyc(); #1 check_eq("rst_rd_ms", ms_v, 16'd3);
        check_eq("rst_rd_en2", en_v, 16'b00000);
        check_eq("rst_rd_byp", byp_v, 16'b0000);
        reset = 1'b0; complete_data = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
